// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter for a shared synchronous ROM read port
// Optional lock feature: define ROM_ARB_LOCK_EN.
module rom_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDRW    = 8,
  parameter int WIDTH    = 4,
  parameter int ROM_LAT  = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic [NREQ-1:0]       req_lock,
  output logic [NREQ-1:0]       gnt,
  output logic [ADDRW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] win_id;
  logic          win_found;
  logic          accept;

  // Tag pipeline: stage ROM_LAT lines up with the returning ROM word.
  logic [ROM_LAT:0] tag_v;
  logic [PW-1:0]    tag_id [ROM_LAT+1];

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
  endfunction

  // Search for the first requester starting at the priority pointer.
  always_comb begin
    logic [PW-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // One-hot grant, forced low while reset is asserted.
  always_comb begin
    gnt = '0;
    if (rst_n && win_found) gnt[win_id] = 1'b1;
  end

  assign accept = rst_n && win_found;

`ifdef ROM_ARB_LOCK_EN
  // Nonzero lock_cnt means requester ptr currently holds the lock.
  logic [7:0] lock_cnt;
  logic [7:0] lock_cnt_nxt;
  logic [7:0] lock_base;

  // Next pointer and lock count, including lock entry, extension and release.
  always_comb begin
    ptr_nxt      = ptr;
    lock_cnt_nxt = lock_cnt;
    lock_base    = (lock_cnt != 8'd0 && req[ptr]) ? lock_cnt : 8'd0;
    if (accept) begin
      if (req_lock[win_id] && lock_base != 8'(MAX_LOCK - 1)) begin
        ptr_nxt      = win_id;
        lock_cnt_nxt = lock_base + 8'd1;
      end else begin
        ptr_nxt      = inc_mod(win_id);
        lock_cnt_nxt = 8'd0;
      end
    end else if (lock_cnt != 8'd0 && !req[ptr]) begin
      ptr_nxt      = inc_mod(ptr);
      lock_cnt_nxt = 8'd0;
    end
  end

  // Lock counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_cnt <= 8'd0;
    else        lock_cnt <= lock_cnt_nxt;
  end
`else
  logic unused_lock;
  localparam int unused_max_lock = MAX_LOCK;
  assign unused_lock = ^req_lock;

  // Pure round-robin: pointer moves past each accepted requester.
  always_comb begin
    ptr_nxt = ptr;
    if (accept) ptr_nxt = inc_mod(win_id);
  end
`endif

  // Priority pointer and ROM address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      rom_addr <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (accept) rom_addr <= req_addr[int'(win_id)*ADDRW +: ADDRW];
    end
  end

  // Shift the requester tag along with the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int s = 0; s <= ROM_LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v     <= {tag_v[ROM_LAT-1:0], accept};
      tag_id[0] <= win_id;
      for (int s = 1; s <= ROM_LAT; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  // Steer the returning word to the requester that issued it.
  always_comb begin
    rsp_valid = '0;
    if (tag_v[ROM_LAT]) rsp_valid[tag_id[ROM_LAT]] = 1'b1;
  end

  assign rsp_data = rom_data;
  assign busy     = |tag_v;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

  localparam int NREQ     = 4;
  localparam int ADDRW    = 8;
  localparam int WIDTH    = 4;
  localparam int ROM_LAT  = 1;
  localparam int MAX_LOCK = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*ADDRW-1:0] req_addr = '0;
  logic [NREQ-1:0]       req_lock = '0;
  logic [NREQ-1:0]       gnt;
  logic [ADDRW-1:0]      rom_addr;
  logic [WIDTH-1:0]      rom_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;

  int pass_cnt = 0;
  int total    = 0;

  rom_arbiter #(
    .NREQ(NREQ), .ADDRW(ADDRW), .WIDTH(WIDTH), .ROM_LAT(ROM_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_lock(req_lock),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_fn(input logic [7:0] a);
    return a[3:0] ^ a[7:4] ^ 4'h5;
  endfunction

  // ROM model with ROM_LAT registered stages.
  logic [WIDTH-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int s = 1; s < ROM_LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else pass_cnt++;
    total++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (rom_addr !== 8'h00) $display("FAIL reset_rom_addr got %h exp 00", rom_addr); else pass_cnt++;
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 4'b0010;
    req_addr = {8'h00, 8'h00, 8'h3C, 8'h00};
    #1;
    total++; if (gnt !== 4'b0010) $display("FAIL single_gnt got %b exp 0010", gnt); else pass_cnt++;
    @(negedge clk);
    req = '0;
    #1;
    total++; if (rom_addr !== 8'h3C) $display("FAIL single_rom_addr got %h exp 3c", rom_addr); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else pass_cnt++;
    total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_early got %b exp 0000", rsp_valid); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 4'b0010) $display("FAIL single_rsp_valid got %b exp 0010", rsp_valid); else pass_cnt++;
    total++; if (rsp_data !== 4'hA) $display("FAIL single_rsp_data got %h exp a", rsp_data); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_once got %b exp 0000", rsp_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL single_idle_busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] a [4];
    logic [3:0] exp_g;
    logic [3:0] exp_r;
    int id;
    a[0] = 8'h05; a[1] = 8'h19; a[2] = 8'h2E; a[3] = 8'h47;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    req_addr = {a[3], a[2], a[1], a[0]};
    for (int n = 0; n < 8; n++) begin
      #1;
      exp_g = 4'b0001 << (n % 4);
      total++; if (gnt !== exp_g) $display("FAIL rr_gnt cycle %0d got %b exp %b", n, gnt, exp_g); else pass_cnt++;
      if (n >= 2) begin
        id = (n - 2) % 4;
        exp_r = 4'b0001 << id;
        total++; if (rsp_valid !== exp_r) $display("FAIL rr_rsp_valid cycle %0d got %b exp %b", n, rsp_valid, exp_r); else pass_cnt++;
        total++; if (rsp_data !== rom_fn(a[id])) $display("FAIL rr_rsp_data cycle %0d got %h exp %h", n, rsp_data, rom_fn(a[id])); else pass_cnt++;
      end else begin
        total++; if (rsp_valid !== 4'b0000) $display("FAIL rr_rsp_early cycle %0d got %b exp 0000", n, rsp_valid); else pass_cnt++;
      end
      if (n >= 1) begin
        total++; if (busy !== 1'b1) $display("FAIL rr_busy cycle %0d got %b exp 1", n, busy); else pass_cnt++;
      end
      @(negedge clk);
    end
    req = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rr_drain_busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_wrap_skip();
    @(negedge clk);
    req = 4'b0100;
    req_addr = {8'h11, 8'h22, 8'h33, 8'h44};
    #1;
    total++; if (gnt !== 4'b0100) $display("FAIL wrap_first got %b exp 0100", gnt); else pass_cnt++;
    @(negedge clk);
    req = 4'b0101;
    #1;
    total++; if (gnt !== 4'b0001) $display("FAIL wrap_to_0 got %b exp 0001", gnt); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (gnt !== 4'b0100) $display("FAIL skip_to_2 got %b exp 0100", gnt); else pass_cnt++;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req = 4'b0011;
    #1;
    total++; if (gnt !== 4'b0001) $display("FAIL mid_gnt0 got %b exp 0001", gnt); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (gnt !== 4'b0010) $display("FAIL mid_gnt1 got %b exp 0010", gnt); else pass_cnt++;
    @(negedge clk);
    req = 4'b1111;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_rsp_valid got %b exp 0000", rsp_valid); else pass_cnt++;
    total++; if (gnt !== 4'b0000) $display("FAIL mid_gnt_in_reset got %b exp 0000", gnt); else pass_cnt++;
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_stale_rsp cycle %0d got %b exp 0000", n, rsp_valid); else pass_cnt++;
      @(negedge clk);
    end
    req = 4'b1111;
    #1;
    total++; if (gnt !== 4'b0001) $display("FAIL mid_first_after got %b exp 0001", gnt); else pass_cnt++;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
  endtask

`ifdef ROM_ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_g;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1100;
    req_lock = 4'b0100;
    for (int n = 0; n < 5; n++) begin
      #1;
      exp_g = (n < 4) ? 4'b0100 : 4'b1000;
      total++; if (gnt !== exp_g) $display("FAIL lock_max cycle %0d got %b exp %b", n, gnt, exp_g); else pass_cnt++;
      @(negedge clk);
    end
    #1;
    total++; if (gnt !== 4'b0100) $display("FAIL lock_regrab got %b exp 0100", gnt); else pass_cnt++;
    @(negedge clk);
    req_lock = 4'b0000;
    #1;
    total++; if (gnt !== 4'b0100) $display("FAIL lock_drop_grant got %b exp 0100", gnt); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (gnt !== 4'b1000) $display("FAIL lock_release got %b exp 1000", gnt); else pass_cnt++;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_reset_mid();
`ifdef ROM_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
